// File: rtl/uart_pkg.sv
// Shared types and oversampling helpers for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRK_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {
        LEN_5 = 2'd0,
        LEN_6 = 2'd1,
        LEN_7 = 2'd2,
        LEN_8 = 2'd3
    } data_len_t;

    localparam int DEFAULT_OSR = 16;

    function automatic int vote_idx_first(input int osr);
        return osr / 2 - 1;
    endfunction

    function automatic int vote_idx_mid(input int osr);
        return osr / 2;
    endfunction

    function automatic int vote_idx_last(input int osr);
        return osr / 2 + 1;
    endfunction

    // Index of the final data bit for a given frame length (5..8 bits -> 4..7)
    function automatic logic [2:0] last_bit_idx(input data_len_t len);
        return {1'b0, len} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake between the UART receiver and its consumer.
interface uart_rx_cfg_if #(
    parameter int MAX_DATA_WIDTH = 8
) ();
    logic [MAX_DATA_WIDTH-1:0] rx_data;
    logic                      rx_parity_err;
    logic                      rx_frame_err;
    logic                      rx_valid;
    logic                      rx_ready;

    modport master (
        output rx_data,
        output rx_parity_err,
        output rx_frame_err,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_vote.sv
// Captures the two samples ahead of mid-bit and forms a 3-way majority with the third.
module uart_rx_vote
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE_RATE = DEFAULT_OSR,
    parameter int CNT_W           = $clog2(OVERSAMPLE_RATE)
) (
    input  logic             uart_clk,
    input  logic             rst_n,
    input  logic             sample_tick,
    input  logic             rx_serial_sync,
    input  logic             window_en,
    input  logic [CNT_W-1:0] sample_cnt,
    output logic             vote_bit,
    output logic             vote_valid
);
    localparam logic [CNT_W-1:0] C_FIRST = CNT_W'(vote_idx_first(OVERSAMPLE_RATE));
    localparam logic [CNT_W-1:0] C_MID   = CNT_W'(vote_idx_mid(OVERSAMPLE_RATE));
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(vote_idx_last(OVERSAMPLE_RATE));

    logic [1:0] samp;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            samp <= 2'b00;
        end else if (sample_tick && window_en &&
                     (sample_cnt == C_FIRST || sample_cnt == C_MID)) begin
            samp <= {samp[0], rx_serial_sync};
        end
    end

    // Third sample is the live input on the tick the vote is consumed
    assign vote_bit   = (samp[1] & samp[0]) | (samp[1] & rx_serial_sync) |
                        (samp[0] & rx_serial_sync);
    assign vote_valid = sample_tick && window_en && (sample_cnt == C_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime frame format, majority-vote sampling and error/break status.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE_RATE = DEFAULT_OSR,
    parameter int MAX_DATA_WIDTH  = 8
) (
    input  logic                 uart_clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx_serial_sync,
    input  logic [1:0]           cfg_data_bits,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_stop2,
    uart_rx_cfg_if.master        rx_if,
    output logic                 overrun_error,
    output logic                 break_detect,
    input  logic                 status_clr,
    output logic                 rx_active
);
    localparam int               CNT_W    = $clog2(OVERSAMPLE_RATE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE_RATE - 1);

    rx_state_t                 state;
    logic [CNT_W-1:0]          sample_cnt;
    logic [2:0]                bit_cnt;
    logic                      edge_q;
    logic [MAX_DATA_WIDTH-1:0] data_sh;
    logic                      par_err;
    logic                      stop_err;
    logic                      all_zero;
    data_len_t                 len_s;
    logic                      par_en_s;
    logic                      par_odd_s;
    logic                      stop2_s;

    logic vote_bit;
    logic vote_valid;
    logic commit_now;
    logic brk_now;
    logic frame_err_now;

    uart_rx_vote #(
        .OVERSAMPLE_RATE (OVERSAMPLE_RATE),
        .CNT_W           (CNT_W)
    ) u_vote (
        .uart_clk       (uart_clk),
        .rst_n          (rst_n),
        .sample_tick    (sample_tick),
        .rx_serial_sync (rx_serial_sync),
        .window_en      (state != ST_IDLE),
        .sample_cnt     (sample_cnt),
        .vote_bit       (vote_bit),
        .vote_valid     (vote_valid)
    );

    // Frame end decode: an all-zero frame through STOP1 is a break, never a byte
    always_comb begin
        commit_now    = 1'b0;
        brk_now       = 1'b0;
        frame_err_now = stop_err | ~vote_bit;
        if (vote_valid) begin
            case (state)
                ST_STOP1: begin
                    if (all_zero && !vote_bit) brk_now = 1'b1;
                    else if (!stop2_s)         commit_now = 1'b1;
                end
                ST_STOP2: commit_now = 1'b1;
                default: ;
            endcase
        end
    end

    assign rx_active = (state != ST_IDLE);

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sample_cnt    <= '0;
            bit_cnt       <= '0;
            edge_q        <= 1'b1;
            data_sh       <= '0;
            par_err       <= 1'b0;
            stop_err      <= 1'b0;
            all_zero      <= 1'b0;
            len_s         <= LEN_5;
            par_en_s      <= 1'b0;
            par_odd_s     <= 1'b0;
            stop2_s       <= 1'b0;
            rx_if.rx_data       <= '0;
            rx_if.rx_parity_err <= 1'b0;
            rx_if.rx_frame_err  <= 1'b0;
            rx_if.rx_valid      <= 1'b0;
            overrun_error <= 1'b0;
            break_detect  <= 1'b0;
        end else begin
            if (sample_tick) begin
                edge_q <= rx_serial_sync;
                if (state != ST_IDLE) begin
                    sample_cnt <= (sample_cnt == CNT_LAST) ? '0 : sample_cnt + 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        if (edge_q && !rx_serial_sync) begin
                            state      <= ST_START;
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            data_sh    <= '0;
                            par_err    <= 1'b0;
                            stop_err   <= 1'b0;
                            all_zero   <= 1'b1;
                            len_s      <= data_len_t'(cfg_data_bits);
                            par_en_s   <= cfg_parity_en;
                            par_odd_s  <= cfg_parity_odd;
                            stop2_s    <= cfg_stop2;
                        end
                    end
                    ST_START: begin
                        if (vote_valid && vote_bit) begin
                            state      <= ST_IDLE;
                            sample_cnt <= '0;
                        end else if (sample_cnt == CNT_LAST) begin
                            state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (vote_valid) begin
                            data_sh[bit_cnt] <= vote_bit;
                            if (vote_bit) all_zero <= 1'b0;
                        end
                        if (sample_cnt == CNT_LAST) begin
                            if (bit_cnt == last_bit_idx(len_s)) begin
                                bit_cnt <= '0;
                                state   <= par_en_s ? ST_PARITY : ST_STOP1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (vote_valid) begin
                            par_err <= ((^data_sh) ^ vote_bit) != par_odd_s;
                            if (vote_bit) all_zero <= 1'b0;
                        end
                        if (sample_cnt == CNT_LAST) state <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        if (vote_valid) stop_err <= frame_err_now;
                        if (brk_now) begin
                            state <= ST_BRK_WAIT;
                        end else if (commit_now) begin
                            state      <= ST_IDLE;
                            sample_cnt <= '0;
                        end else if (sample_cnt == CNT_LAST) begin
                            state <= ST_STOP2;
                        end
                    end
                    ST_STOP2: begin
                        if (commit_now) begin
                            state      <= ST_IDLE;
                            sample_cnt <= '0;
                        end
                    end
                    ST_BRK_WAIT: begin
                        if (rx_serial_sync) begin
                            state      <= ST_IDLE;
                            sample_cnt <= '0;
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        sample_cnt <= '0;
                    end
                endcase
            end

            // Consumer handshake; a held, unaccepted byte blocks the new one
            if (commit_now) begin
                if (rx_if.rx_valid && !rx_if.rx_ready) begin
                    overrun_error <= 1'b1;
                end else begin
                    rx_if.rx_data       <= data_sh;
                    rx_if.rx_parity_err <= par_err;
                    rx_if.rx_frame_err  <= frame_err_now;
                    rx_if.rx_valid      <= 1'b1;
                end
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end

            if (status_clr) begin
                if (!(commit_now && rx_if.rx_valid && !rx_if.rx_ready)) overrun_error <= 1'b0;
                if (!brk_now) break_detect <= 1'b0;
            end
            if (brk_now) break_detect <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: serial frames driven tick by tick, bytes checked on handshake.
module tb_uart_rx_cfg;
    localparam int OSR = 16;

    logic       uart_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx_serial_sync = 1'b1;
    logic [1:0] cfg_data_bits = 2'd3;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_parity_odd = 1'b0;
    logic       cfg_stop2 = 1'b0;
    logic       status_clr = 1'b0;
    logic       overrun_error;
    logic       break_detect;
    logic       rx_active;

    uart_rx_cfg_if #(.MAX_DATA_WIDTH(8)) rx_if ();

    uart_rx_cfg #(
        .OVERSAMPLE_RATE (OSR),
        .MAX_DATA_WIDTH  (8)
    ) dut (
        .uart_clk       (uart_clk),
        .rst_n          (rst_n),
        .sample_tick    (sample_tick),
        .rx_serial_sync (rx_serial_sync),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_if          (rx_if.master),
        .overrun_error  (overrun_error),
        .break_detect   (break_detect),
        .status_clr     (status_clr),
        .rx_active      (rx_active)
    );

    always #5 uart_clk = ~uart_clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_rx  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accepted bytes are compared against the oldest expectation
    always @(negedge uart_clk) begin
        if (rst_n && rx_if.rx_valid && rx_if.rx_ready) begin
            n_rx++;
            if (sb_q.size() == 0) begin
                chk("unexpected_byte", 32'(sb_q.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rx_data", 32'(rx_if.rx_data), 32'(e.d));
                chk("rx_parity_err", 32'(rx_if.rx_parity_err), 32'(e.pe));
                chk("rx_frame_err", 32'(rx_if.rx_frame_err), 32'(e.fe));
            end
        end
    end

    task automatic tick(input logic v);
        rx_serial_sync = v;
        @(negedge uart_clk);
        sample_tick = 1'b1;
        @(negedge uart_clk);
        sample_tick = 1'b0;
        @(negedge uart_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    task automatic send_bit(input logic v, input bit noise);
        for (int k = 0; k < OSR; k++) tick((noise && k == OSR / 2) ? ~v : v);
    endtask

    task automatic set_cfg(input int nbits, input bit pen, input bit podd, input bit st2);
        cfg_data_bits  = 2'(nbits - 5);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        cfg_stop2      = st2;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit podd,
                              input bit pflip, input bit st2, input bit noise, input bit bad_stop);
        logic [7:0] dm;
        logic       p;
        dm = d & 8'((1 << nbits) - 1);
        p  = (^dm) ^ podd ^ pflip;
        send_bit(1'b0, noise);
        for (int i = 0; i < nbits; i++) send_bit(dm[i], noise);
        if (pen) send_bit(p, noise);
        send_bit(~bad_stop, noise);
        if (st2) send_bit(1'b1, noise);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        sb_q.push_back(e);
    endtask

    task automatic set_ready(input logic v);
        @(posedge uart_clk);
        #1 rx_if.rx_ready = v;
    endtask

    task automatic pulse_clr();
        @(posedge uart_clk);
        #1 status_clr = 1'b1;
        @(posedge uart_clk);
        #1 status_clr = 1'b0;
    endtask

    initial begin
        rx_if.rx_ready = 1'b1;
        #23;
        chk("reset_rx_valid", 32'(rx_if.rx_valid), 32'd0);
        chk("reset_rx_data", 32'(rx_if.rx_data), 32'd0);
        chk("reset_rx_active", 32'(rx_active), 32'd0);
        chk("reset_overrun", 32'(overrun_error), 32'd0);
        chk("reset_break", 32'(break_detect), 32'd0);
        @(negedge uart_clk);
        rst_n = 1'b1;
        idle(8);

        // 8N1 basic byte, then a byte with a low stop bit
        set_cfg(8, 0, 0, 0);
        push_exp(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0);
        idle(20);
        chk("one_byte_8n1", 32'(n_rx), 32'd1);
        push_exp(8'h81, 1'b0, 1'b1);
        send_frame(8'h81, 8, 0, 0, 0, 0, 0, 1);
        idle(20);

        // 7E2 good and bad parity
        set_cfg(7, 1, 0, 1);
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 7, 1, 0, 0, 1, 0, 0);
        push_exp(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 7, 1, 0, 1, 1, 0, 0);
        idle(20);

        // Idle-line glitch, then a noisy byte
        set_cfg(8, 0, 0, 0);
        tick(1'b0);
        idle(30);
        chk("glitch_rx_active", 32'(rx_active), 32'd0);
        push_exp(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 8, 0, 0, 0, 0, 1, 0);
        idle(20);
        chk("after_noise_count", 32'(n_rx), 32'd5);

        // Overrun: second byte dropped while the first is held
        set_ready(1'b0);
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 8, 0, 0, 0, 0, 0, 0);
        send_frame(8'h22, 8, 0, 0, 0, 0, 0, 0);
        idle(20);
        chk("overrun_set", 32'(overrun_error), 32'd1);
        chk("overrun_held_data", 32'(rx_if.rx_data), 32'h11);
        chk("overrun_held_valid", 32'(rx_if.rx_valid), 32'd1);
        set_ready(1'b1);
        idle(2);
        chk("overrun_sticky", 32'(overrun_error), 32'd1);
        chk("valid_dropped", 32'(rx_if.rx_valid), 32'd0);
        pulse_clr();
        chk("overrun_cleared", 32'(overrun_error), 32'd0);

        // Break of 12 bit-times, then a normal byte
        for (int i = 0; i < 12 * OSR; i++) tick(1'b0);
        idle(32);
        chk("break_set", 32'(break_detect), 32'd1);
        chk("break_no_byte", 32'(n_rx), 32'd6);
        push_exp(8'h7E, 1'b0, 1'b0);
        send_frame(8'h7E, 8, 0, 0, 0, 0, 0, 0);
        idle(20);
        chk("after_break_count", 32'(n_rx), 32'd7);
        pulse_clr();
        chk("break_cleared", 32'(break_detect), 32'd0);

        // Reset in the middle of a data field
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        chk("mid_frame_active", 32'(rx_active), 32'd1);
        @(posedge uart_clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst_rx_active", 32'(rx_active), 32'd0);
        chk("midrst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
        chk("midrst_rx_data", 32'(rx_if.rx_data), 32'd0);
        chk("midrst_flags", 32'({rx_if.rx_parity_err, rx_if.rx_frame_err,
                                 overrun_error, break_detect}), 32'd0);
        rx_serial_sync = 1'b1;
        repeat (3) @(posedge uart_clk);
        @(negedge uart_clk);
        rst_n = 1'b1;
        idle(20);
        set_cfg(5, 0, 0, 0);
        push_exp(8'h1F, 1'b0, 1'b0);
        send_frame(8'h1F, 5, 0, 0, 0, 0, 0, 0);
        idle(20);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        chk("total_bytes", 32'(n_rx), 32'd8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
